// File: rtl/addsub_arbiter.sv
// Round-robin sequencer for the shared add/sub unit. It serves two requesters and
// returns a registered result, carry and signed overflow with a one-cycle ack.
module addsub_arbiter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         sub0,
    input  logic         sub1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         ovf,
    output logic         done,
    output logic         done_id,
    output logic         busy,
    output logic [W-1:0] au_a,
    output logic [W-1:0] au_b,
    output logic         au_sub,
    input  logic [W-1:0] au_result,
    input  logic         au_carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_gnt_q, last_gnt_d;
    logic           gnt_id_q, gnt_id_d;
    logic [W-1:0]   au_a_q, au_a_d;
    logic [W-1:0]   au_b_q, au_b_d;
    logic           au_sub_q, au_sub_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_q, carry_d;
    logic           ovf_q, ovf_d;
    logic           done_id_q, done_id_d;

    logic           gnt_sel;
    logic [W-1:0]   b_eff;
    logic           ovf_calc;
    logic [1:0]     ack_vec;

    // On a tie the port that did not win last time is granted.
    assign gnt_sel  = (req0 && req1) ? ~last_gnt_q : req1;

    assign b_eff    = au_sub_q ? ~au_b_q : au_b_q;
    assign ovf_calc = (au_a_q[W-1] == b_eff[W-1]) && (au_result[W-1] != au_a_q[W-1]);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_id_d   = gnt_id_q;
        au_a_d     = au_a_q;
        au_b_d     = au_b_q;
        au_sub_d   = au_sub_q;
        result_d   = result_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        done_id_d  = done_id_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d    = DRIVE;
                    gnt_id_d   = gnt_sel;
                    last_gnt_d = gnt_sel;
                    au_a_d     = gnt_sel ? a1 : a0;
                    au_b_d     = gnt_sel ? b1 : b0;
                    au_sub_d   = gnt_sel ? sub1 : sub0;
                end
            end
            DRIVE: begin
                state_d   = DONE;
                result_d  = au_result;
                carry_d   = au_carry;
                ovf_d     = ovf_calc;
                done_id_d = gnt_id_q;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_id_q   <= 1'b0;
            au_a_q     <= '0;
            au_b_q     <= '0;
            au_sub_q   <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            done_id_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_id_q   <= gnt_id_d;
            au_a_q     <= au_a_d;
            au_b_q     <= au_b_d;
            au_sub_q   <= au_sub_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            done_id_q  <= done_id_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = (state_q == DONE) && (gnt_id_q == 1'(gi));
        end
    endgenerate

    assign ack0    = ack_vec[0];
    assign ack1    = ack_vec[1];
    assign done    = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign result  = result_q;
    assign carry   = carry_q;
    assign ovf     = ovf_q;
    assign done_id = done_id_q;
    assign au_a    = au_a_q;
    assign au_b    = au_b_q;
    assign au_sub  = au_sub_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed cases plus random traffic against an
// arithmetic reference model of the arbiter and the add/sub unit.
module tb_addsub_arbiter;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, sub0 = 1'b0, sub1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         ack0, ack1, carry, ovf, done, done_id, busy, au_sub, au_carry;
    logic [W-1:0] result, au_a, au_b, au_result;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_last = 1'b1;

    always #5 clk = ~clk;

    // Stand-in for the shared add/sub unit: subtraction is a + ~b + 1.
    assign {au_carry, au_result} = au_sub ? ({1'b0, au_a} + {1'b0, ~au_b} + 7'd1)
                                          : ({1'b0, au_a} + {1'b0, au_b});

    addsub_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .result(result), .carry(carry), .ovf(ovf),
        .done(done), .done_id(done_id), .busy(busy),
        .au_a(au_a), .au_b(au_b), .au_sub(au_sub),
        .au_result(au_result), .au_carry(au_carry)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("one_ack", {31'd0, ack0 & ack1}, 0);
        check("done_vs_ack", {31'd0, done}, {31'd0, ack0 | ack1});
    end

    // Called at a negedge with the DUT idle. Applies requests, predicts the grant and
    // the arithmetic, then follows the operation through to its ack.
    task automatic serve(input bit r0, input bit r1,
                         input bit s0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input bit s1, input logic [W-1:0] x1, input logic [W-1:0] y1,
                         input bit drop, input bit scramble, output int served);
        bit g, es, ec, eo;
        int ia, ib, sa, sb, sr, k;
        logic [W-1:0] er;
        req0 = r0; req1 = r1; sub0 = s0; a0 = x0; b0 = y0; sub1 = s1; a1 = x1; b1 = y1;
        served = -1;
        if (!r0 && !r1) begin
            @(negedge clk);
            check("idle_busy", {31'd0, busy}, 0);
            return;
        end
        g  = (r0 && r1) ? !model_last : r1;
        model_last = g;
        ia = g ? int'(x1) : int'(x0);
        ib = g ? int'(y1) : int'(y0);
        es = g ? s1 : s0;
        if (es) begin
            er = W'((ia - ib + 64) % 64);
            ec = (ia >= ib);
        end else begin
            er = W'((ia + ib) % 64);
            ec = (ia + ib) > 63;
        end
        sa = (ia >= 32) ? ia - 64 : ia;
        sb = (ib >= 32) ? ib - 64 : ib;
        sr = es ? sa - sb : sa + sb;
        eo = (sr > 31) || (sr < -32);

        @(negedge clk);
        check("drive_busy", {31'd0, busy}, 1);
        check("drive_ack", {30'd0, ack1, ack0}, 0);
        check("drive_au_a", {26'd0, au_a}, ia);
        check("drive_au_sub", {31'd0, au_sub}, {31'd0, es});
        if (scramble) begin
            a0 = 6'h3F; b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            sub0 = !sub0; sub1 = !sub1;
        end
        if (drop) begin
            req0 = 1'b0; req1 = 1'b0;
        end
        k = 1;
        while (!(ack0 || ack1) && k < 6) begin
            @(negedge clk);
            k++;
        end
        check("ack_latency", k, 2);
        check("ack_port", {30'd0, ack1, ack0}, g ? 2 : 1);
        check("done_id", {31'd0, done_id}, {31'd0, g});
        check("result", {26'd0, result}, {26'd0, er});
        check("carry", {31'd0, carry}, {31'd0, ec});
        check("ovf", {31'd0, ovf}, {31'd0, eo});
        served = int'(done_id);
        $display("op port=%0d sub=%0d a=0x%02h b=0x%02h -> result=0x%02h carry=%0d ovf=%0d",
                 g, es, ia, ib, result, carry, ovf);
        if (g) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        check("ack_width", {30'd0, ack1, ack0}, 0);
        check("idle_after", {31'd0, busy}, 0);
        check("result_hold", {26'd0, result}, {26'd0, er});
    endtask

    initial begin
        int sv;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_outs", {12'd0, ack0, ack1, done, done_id, au_sub, carry, ovf, result, au_a, au_b}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both requesters held from reset: strict alternation starting at 0.
        for (int i = 0; i < 4; i++) begin
            serve(1, 1, 0, W'(i), 6'h01, 1, 6'h10, W'(i), 0, 0, sv);
            check("tie_order", sv, i % 2);
        end

        serve(1, 0, 0, 6'h02, 6'h03, 0, 6'h00, 6'h00, 0, 0, sv);
        serve(0, 1, 0, 6'h00, 6'h00, 1, 6'h06, 6'h03, 0, 0, sv);
        serve(0, 1, 0, 6'h00, 6'h00, 1, 6'h04, 6'h07, 0, 0, sv);
        serve(1, 0, 0, 6'h1F, 6'h01, 0, 6'h00, 6'h00, 0, 0, sv);
        serve(1, 0, 1, 6'h20, 6'h01, 0, 6'h00, 6'h00, 0, 0, sv);
        // Operands change during DRIVE; request dropped before ack.
        serve(1, 0, 0, 6'h02, 6'h03, 0, 6'h00, 6'h00, 0, 1, sv);
        serve(1, 0, 0, 6'h0A, 6'h05, 0, 6'h00, 6'h00, 1, 0, sv);

        // Reset asserted during DRIVE.
        req0 = 1'b1; req1 = 1'b0; sub0 = 1'b0; a0 = 6'h02; b0 = 6'h03;
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {12'd0, ack0, ack1, done, done_id, au_sub, carry, ovf, result, au_a, au_b}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        model_last = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_done", {31'd0, done}, 0);
        rst_n = 1'b1;
        serve(1, 0, 0, 6'h02, 6'h03, 0, 6'h00, 6'h00, 0, 0, sv);

        for (int i = 0; i < 40; i++) begin
            serve(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                  1'($urandom), W'($urandom), W'($urandom),
                  ($urandom % 4) == 0, ($urandom % 4) == 0, sv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
